// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch unit with redirect, halt and misalign detection.
module ifu #(
  parameter int PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_resp_data,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [PC_WIDTH-1:0] inst_pc,
  input  logic                inst_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  output logic                halted,
  output logic                misalign_err,
  output logic [63:0]         fetch_cnt
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALTED} state_t;
  state_t state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n, inst_pc_n;
  logic [31:0] inst_n;
  logic [63:0] cnt_n;
  logic drop, drop_n, halt_pend, halt_pend_n, mis_n;
  logic req_hs, mis, live, redir_ok, stop, drop_eff, pend_eff;
  assign imem_req_valid = rst_n & (state == REQ);
  assign imem_req_addr = pc;
  assign inst_valid = state == HOLD;
  assign halted = state == HALTED;
  assign req_hs = imem_req_valid & imem_req_ready;
  assign mis = redirect_pc[1:0] != 2'b00;
  assign live = state != HALTED;
  assign redir_ok = live & redirect_valid & ~halt & ~mis;
  // halt outranks redirect; a misaligned redirect stops fetch like a halt
  assign stop = halt | (redirect_valid & mis);
  assign drop_eff = drop | halt | redirect_valid;
  assign pend_eff = halt_pend | stop;
  always_comb begin
    state_n = state;
    pc_n = redir_ok ? redirect_pc : pc;
    mis_n = misalign_err | (live & redirect_valid & ~halt & mis);
    drop_n = drop;
    halt_pend_n = halt_pend;
    inst_n = inst;
    inst_pc_n = inst_pc;
    cnt_n = fetch_cnt;
    case (state)
      REQ: begin
        state_n = req_hs ? WAIT : stop ? HALTED : REQ;
        drop_n = req_hs & (halt | redirect_valid);
        halt_pend_n = req_hs & stop;
      end
      WAIT: begin
        drop_n = imem_resp_valid ? 1'b0 : drop_eff;
        halt_pend_n = pend_eff;
        state_n = !imem_resp_valid ? WAIT : !drop_eff ? HOLD : pend_eff ? HALTED : REQ;
        inst_n = (imem_resp_valid && !drop_eff) ? imem_resp_data : inst;
        inst_pc_n = (imem_resp_valid && !drop_eff) ? pc : inst_pc;
      end
      HOLD: begin
        state_n = stop ? HALTED : (redirect_valid || inst_ready) ? REQ : HOLD;
        if (!stop && !redirect_valid && inst_ready) begin
          pc_n = pc + PC_WIDTH'(4);
          cnt_n = fetch_cnt + 64'd1;
        end
      end
      default: state_n = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pc <= RESET_PC;
      drop <= 1'b0;
      halt_pend <= 1'b0;
      inst <= 32'h0;
      inst_pc <= '0;
      misalign_err <= 1'b0;
      fetch_cnt <= 64'd0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drop <= drop_n;
      halt_pend <= halt_pend_n;
      inst <= inst_n;
      inst_pc <= inst_pc_n;
      misalign_err <= mis_n;
      fetch_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed and randomized checks of ifu against a stream-level fetch model.
module tb_ifu;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WPC = 64'hffff_ffff_ffff_fffc;
  logic clk = 0, rst_n = 0;
  logic imem_req_ready = 0, imem_resp_valid = 0, inst_ready = 0, redirect_valid = 0, halt = 0;
  logic [31:0] imem_resp_data = 0;
  logic [63:0] redirect_pc = 0;
  logic imem_req_valid, inst_valid, halted, misalign_err;
  logic [63:0] imem_req_addr, inst_pc, fetch_cnt;
  logic [31:0] inst;
  logic w_req_valid, w_inst_valid, w_halted, w_mis;
  logic [63:0] w_addr, w_inst_pc, w_cnt;
  logic [31:0] w_inst;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  ifu dut (.clk(clk), .rst_n(rst_n), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .halted(halted),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt));
  ifu #(.RESET_PC(WPC)) dut_w (.clk(clk), .rst_n(rst_n), .imem_req_valid(w_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(w_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .halted(w_halted), .misalign_err(w_mis), .fetch_cnt(w_cnt));

  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] * 32'h9e3779b1 + 32'h7;
  endfunction
  task automatic tick; @(posedge clk); #1; endtask
  task automatic idle;
    imem_req_ready = 0; imem_resp_valid = 0; inst_ready = 0; redirect_valid = 0; halt = 0;
  endtask
  task automatic do_reset; idle; rst_n = 0; tick; rst_n = 1; endtask
  task automatic get(input logic [31:0] d);
    imem_req_ready = 1; tick; imem_req_ready = 0;
    imem_resp_valid = 1; imem_resp_data = d; tick; imem_resp_valid = 0;
  endtask

  task automatic test_reset;
    idle; rst_n = 0; #12;
    vecs++; if (imem_req_valid !== 0 || inst_valid !== 0 || halted !== 0 || misalign_err !== 0 || fetch_cnt !== 0) begin
      errs++; $display("FAIL reset_state req=%b iv=%b h=%b m=%b cnt=%0d expected 0s", imem_req_valid, inst_valid, halted, misalign_err, fetch_cnt); end
    tick; rst_n = 1; #1;
    vecs++; if (imem_req_valid !== 1 || imem_req_addr !== RPC) begin
      errs++; $display("FAIL reset_release req=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RPC); end
  endtask

  task automatic test_basic;
    imem_req_ready = 1; tick; imem_req_ready = 0;
    vecs++; if (imem_req_valid !== 0 || inst_valid !== 0) begin
      errs++; $display("FAIL basic_wait req=%b iv=%b expected 0 0", imem_req_valid, inst_valid); end
    imem_resp_valid = 1; imem_resp_data = 32'h00100093; tick; imem_resp_valid = 0;
    vecs++; if (inst_valid !== 1 || inst !== 32'h00100093 || inst_pc !== RPC) begin
      errs++; $display("FAIL basic_inst iv=%b inst=%h pc=%h expected 1 00100093 %h", inst_valid, inst, inst_pc, RPC); end
    inst_ready = 1; tick; inst_ready = 0;
    vecs++; if (fetch_cnt !== 1 || imem_req_valid !== 1 || imem_req_addr !== RPC + 4) begin
      errs++; $display("FAIL basic_next cnt=%0d req=%b addr=%h expected 1 1 %h", fetch_cnt, imem_req_valid, imem_req_addr, RPC + 4); end
  endtask

  task automatic test_hold;
    get(32'hdeadbeef); imem_req_ready = 1;
    for (int i = 0; i < 5; i++) begin
      vecs++; if (inst_valid !== 1 || inst !== 32'hdeadbeef || inst_pc !== RPC + 4 || imem_req_valid !== 0 || fetch_cnt !== 1) begin
        errs++; $display("FAIL hold_stable iv=%b inst=%h pc=%h req=%b cnt=%0d", inst_valid, inst, inst_pc, imem_req_valid, fetch_cnt); end
      tick;
    end
    imem_req_ready = 0; inst_ready = 1; tick; inst_ready = 0;
    vecs++; if (fetch_cnt !== 2 || imem_req_addr !== RPC + 8) begin
      errs++; $display("FAIL hold_release cnt=%0d addr=%h expected 2 %h", fetch_cnt, imem_req_addr, RPC + 8); end
  endtask

  task automatic test_redirect_wait;
    imem_req_ready = 1; tick; imem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'h8000_0100; tick; redirect_valid = 0;
    imem_resp_valid = 1; imem_resp_data = 32'h12345678; tick; imem_resp_valid = 0;
    vecs++; if (inst_valid !== 0 || imem_req_valid !== 1 || imem_req_addr !== 64'h8000_0100) begin
      errs++; $display("FAIL redirect_wait iv=%b req=%b addr=%h expected 0 1 80000100", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_hold;
    get(32'h0badf00d);
    inst_ready = 1; redirect_valid = 1; redirect_pc = 64'h8000_0200; tick; inst_ready = 0; redirect_valid = 0;
    vecs++; if (fetch_cnt !== 2 || inst_valid !== 0 || imem_req_valid !== 1 || imem_req_addr !== 64'h8000_0200) begin
      errs++; $display("FAIL redirect_hold cnt=%0d iv=%b req=%b addr=%h expected 2 0 1 80000200", fetch_cnt, inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_random;
    logic [63:0] exp_pc = 64'h8000_0200, exp_cnt = 2, pend_addr = 0, tgt;
    logic pend = 0, hs, ihs;
    int delay = 0, got = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_req_ready = 1'($urandom % 2);
      inst_ready = 1'($urandom % 2);
      redirect_valid = ($urandom % 16) == 0;
      tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
      redirect_pc = tgt;
      if (pend && delay == 0) begin imem_resp_valid = 1; imem_resp_data = f(pend_addr); pend = 0; end
      else if (pend) begin imem_resp_valid = 0; delay--; end
      else begin imem_resp_valid = ($urandom % 8) == 0; imem_resp_data = $urandom; end
      hs = imem_req_valid & imem_req_ready;
      ihs = inst_valid & inst_ready & ~redirect_valid;
      if (ihs) begin
        vecs++; if (inst_pc !== exp_pc || inst !== f(exp_pc)) begin
          errs++; $display("FAIL rand_inst pc=%h inst=%h expected %h %h", inst_pc, inst, exp_pc, f(exp_pc)); end
        exp_pc += 4; exp_cnt++; got++;
      end
      if (redirect_valid) exp_pc = tgt;
      if (hs) begin pend = 1; pend_addr = imem_req_addr; delay = int'($urandom % 3); end
      tick;
      vecs++; if (fetch_cnt !== exp_cnt) begin
        errs++; $display("FAIL rand_cnt cnt=%0d expected %0d", fetch_cnt, exp_cnt); end
    end
    idle;
    vecs++; if (got < 200 || halted !== 0) begin
      errs++; $display("FAIL rand_progress delivered=%0d halted=%b expected >=200 0", got, halted); end
  endtask

  task automatic test_halt;
    do_reset; imem_req_ready = 1; tick; imem_req_ready = 0;
    halt = 1; tick; halt = 0;
    vecs++; if (halted !== 0 || imem_req_valid !== 0) begin
      errs++; $display("FAIL halt_drain halted=%b req=%b expected 0 0", halted, imem_req_valid); end
    imem_resp_valid = 1; imem_resp_data = 32'h1; tick; imem_resp_valid = 0; imem_req_ready = 1;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (halted !== 1 || imem_req_valid !== 0 || inst_valid !== 0) begin
        errs++; $display("FAIL halt_wait halted=%b req=%b iv=%b expected 1 0 0", halted, imem_req_valid, inst_valid); end
      tick;
    end
    do_reset; redirect_valid = 1; redirect_pc = 64'h8000_0002; tick; redirect_valid = 0;
    vecs++; if (misalign_err !== 1 || halted !== 1 || imem_req_addr !== RPC) begin
      errs++; $display("FAIL misalign m=%b halted=%b addr=%h expected 1 1 %h", misalign_err, halted, imem_req_addr, RPC); end
    do_reset; halt = 1; redirect_valid = 1; redirect_pc = 64'h8000_0400; tick; idle;
    vecs++; if (halted !== 1 || misalign_err !== 0 || imem_req_addr !== RPC) begin
      errs++; $display("FAIL halt_prio halted=%b m=%b addr=%h expected 1 0 %h", halted, misalign_err, imem_req_addr, RPC); end
    do_reset; get(32'h2); halt = 1; inst_ready = 1; tick; idle;
    vecs++; if (halted !== 1 || fetch_cnt !== 0 || inst_valid !== 0) begin
      errs++; $display("FAIL halt_hold halted=%b cnt=%0d iv=%b expected 1 0 0", halted, fetch_cnt, inst_valid); end
  endtask

  task automatic test_reset_wait;
    do_reset; imem_req_ready = 1; tick; imem_req_ready = 0;
    rst_n = 0; #2;
    vecs++; if (imem_req_valid !== 0) begin
      errs++; $display("FAIL reset_async req=%b expected 0", imem_req_valid); end
    tick; rst_n = 1;
    imem_resp_valid = 1; imem_resp_data = 32'h00100093; tick; imem_resp_valid = 0;
    vecs++; if (inst_valid !== 0 || imem_req_valid !== 1 || imem_req_addr !== RPC) begin
      errs++; $display("FAIL reset_wait iv=%b req=%b addr=%h expected 0 1 %h", inst_valid, imem_req_valid, imem_req_addr, RPC); end
  endtask

  task automatic test_wrap;
    do_reset; get(32'h3);
    vecs++; if (w_inst_valid !== 1 || w_inst_pc !== WPC) begin
      errs++; $display("FAIL wrap_inst iv=%b pc=%h expected 1 %h", w_inst_valid, w_inst_pc, WPC); end
    inst_ready = 1; tick; inst_ready = 0;
    vecs++; if (w_addr !== 64'h0 || w_cnt !== 1) begin
      errs++; $display("FAIL wrap_pc addr=%h cnt=%0d expected 0 1", w_addr, w_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_redirect_wait;
    test_redirect_hold;
    test_random;
    test_halt;
    test_reset_wait;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
